// File: rtl/mem_arbiter.sv
// mem_arbiter: shares an 8-bit byte memory between a fetch port and a data
// port, each issuing 16-bit little-endian word accesses. Each word is moved as
// two byte cycles. When both ports request together, the port that was not
// served last wins (round-robin).
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | sample requests, latch the winner's access, no memory strobe
// BYTE0 | strobe low byte at the latched address
// BYTE1 | strobe high byte at address+1; capture the low read byte
// DONE  | no strobe; read word = {mem_rdata, low byte}; owner's ack pulses
module mem_arbiter #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [15:0]       if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [15:0]       dm_wdata,
  output logic              dm_ack,
  output logic [15:0]       dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BYTE0 = 2'd1;
  localparam logic [1:0] BYTE1 = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]        state;
  logic              owner_dm;   // 1 = data port owns the in-flight access
  logic              last_dm;    // owner of the most recent grant
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [15:0]       lat_wdata;
  logic [7:0]        lo_byte;
  logic              grant_dm;
  logic [15:0]       rd_word;

  // Data port wins when alone, or on a conflict when fetch was served last.
  assign grant_dm = dm_req & (~if_req | ~last_dm);

  // The high byte is never stored: it is on mem_rdata throughout DONE.
  assign rd_word = {mem_rdata, lo_byte};

  // Sequencer and access latches; a reset aborts any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      owner_dm  <= 1'b0;
      last_dm   <= 1'b1;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lo_byte   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (if_req || dm_req) begin
            owner_dm  <= grant_dm;
            last_dm   <= grant_dm;
            lat_we    <= grant_dm ? dm_we : 1'b0;
            lat_addr  <= grant_dm ? dm_addr : if_addr;
            lat_wdata <= grant_dm ? dm_wdata : 16'h0000;
            state     <= BYTE0;
          end
        end
        BYTE0: state <= BYTE1;
        BYTE1: begin
          if (!lat_we) lo_byte <= mem_rdata;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memory strobes, completion pulses and read-word presentation.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if_ack    = 1'b0;
    dm_ack    = 1'b0;
    if_rdata  = '0;
    dm_rdata  = '0;
    case (state)
      BYTE0: begin
        mem_en    = 1'b1;
        mem_we    = lat_we;
        mem_addr  = lat_addr;
        mem_wdata = lat_wdata[7:0];
      end
      BYTE1: begin
        mem_en    = 1'b1;
        mem_we    = lat_we;
        mem_addr  = lat_addr + ADDR_W'(1);
        mem_wdata = lat_wdata[15:8];
      end
      DONE: begin
        if_ack = ~owner_dm;
        dm_ack = owner_dm;
        if (!lat_we) begin
          if (owner_dm) dm_rdata = rd_word;
          else          if_rdata = rd_word;
        end
      end
      default: ;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, byte-address width of the shared memory.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port if_req  input  1  fetch-side word read request.
REQ-005 SHALL have port if_addr  input  ADDR_W  fetch word byte-address.
REQ-006 SHALL have port if_ack  output  1  one-cycle fetch completion pulse.
REQ-007 SHALL have port if_rdata  output  16  fetched word, valid while if_ack=1.
REQ-008 SHALL have port dm_req  input  1  data-side word request.
REQ-009 SHALL have port dm_we  input  1  1=write, 0=read.
REQ-010 SHALL have port dm_addr  input  ADDR_W  data word byte-address.
REQ-011 SHALL have port dm_wdata  input  16  write word.
REQ-012 SHALL have port dm_ack  output  1  one-cycle data completion pulse.
REQ-013 SHALL have port dm_rdata  output  16  read word, valid while dm_ack=1.
REQ-014 SHALL have port mem_en  output  1  byte memory access strobe.
REQ-015 SHALL have port mem_we  output  1  byte write enable, qualified by mem_en.
REQ-016 SHALL have port mem_addr  output  ADDR_W  byte address.
REQ-017 SHALL have port mem_wdata  output  8  write byte.
REQ-018 SHALL have port mem_rdata  input  8  read byte, valid the cycle after a read strobe.
REQ-019 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-020 SHALL implement FSM IDLE -> BYTE0 -> BYTE1 -> DONE -> IDLE, one cycle per non-IDLE state.
REQ-021 SHALL, in IDLE, sample requests each edge; with any req=1, latch owner, address, we and wdata, then enter BYTE0.
REQ-022 SHALL, when only one req=1, grant that requester.
REQ-023 SHALL, when both req=1, grant the requester not granted last (round-robin); last-owner register resets to "data" so the first conflict grants fetch.
REQ-024 SHALL, in BYTE0, drive mem_en=1, mem_addr=latched addr, mem_we=latched we, mem_wdata=wdata[7:0].
REQ-025 SHALL, in BYTE1, drive mem_en=1, mem_addr=addr+1 modulo 2^ADDR_W, mem_we=latched we, mem_wdata=wdata[15:8]; capture mem_rdata into the low result byte on reads.
REQ-026 SHALL, in DONE, drive mem_en=0, capture mem_rdata into the high result byte on reads, and pulse the owner's ack for exactly one cycle.
REQ-027 SHALL present rdata combinationally as {mem_rdata, low byte} during DONE; rdata is 0 outside ack for reads and always 0 for writes.
REQ-028 SHALL assemble words little-endian; odd (unaligned) addresses are legal and need no special handling.
REQ-029 SHALL give latency of exactly 3 cycles from the granting edge to the ack cycle; a new grant is possible on the edge ending DONE+1 (IDLE), i.e. 4-cycle issue interval.
REQ-030 SHALL ignore req of both requesters in BYTE0, BYTE1 and DONE; a non-owner stays pending and is served next.
REQ-031 SHALL treat req still high in IDLE after an ack as a new request; requesters deassert req after ack unless issuing back-to-back.
REQ-032 SHALL hold inputs only until grant; later changes to addr/we/wdata do not affect an in-flight access.
REQ-033 SHALL drive mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0 in IDLE.
REQ-034 SHALL never assert if_ack and dm_ack in the same cycle.

Reset
REQ-035 SHALL, on rst=1 at any time, immediately force state IDLE, all outputs 0, latched regs 0, last-owner=data.
REQ-036 SHALL, on rst mid-transaction, abort with no ack and no further memory strobes; a write reset after BYTE0 leaves only the low byte written.
REQ-037 SHALL resume arbitration on the first rising edge after rst deasserts.

Verification
REQ-038 SHALL verify fetch read: mem[0x0100]=0x34, mem[0x0101]=0x12, if_req addr 0x0100 -> if_ack 3 cycles after grant, if_rdata=0x1234.
REQ-039 SHALL verify data write: dm_we=1 addr 0x0203 wdata 0xBEEF -> byte writes 0xEF@0x0203 then 0xBE@0x0204, dm_ack, dm_rdata=0.
REQ-040 SHALL verify wrap: dm read addr 0xFFFF with mem[0xFFFF]=0xCD, mem[0x0000]=0xAB -> dm_rdata=0xABCD.
REQ-041 SHALL verify contention: both req held from reset -> grants IF, DM, IF, DM alternating, acks never coincident.
REQ-042 SHALL verify reset during BYTE1 of write 0x5566 to 0x0010 -> mem[0x0010]=0x66, mem[0x0011] unchanged, no dm_ack, busy=0.
REQ-043 SHALL verify pending request: dm_req rises during fetch's BYTE0 -> dm granted in the IDLE cycle after if_ack.
